// File: rtl/flash_read_cache_pkg.sv
// Shared definitions for the flash read cache: FSM state encoding and default geometry.
package flash_read_cache_pkg;

  localparam int FLASH_CACHE_INDEX_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } FlashCacheState_t;

endpackage

// File: rtl/flash_cache_array.sv
// Direct-mapped line storage: valid/tag/data per line, combinational lookup,
// one fill port and a single-cycle invalidate of every line.
module flash_cache_array #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] lookup_index_i,
  input  logic [TAG_BITS-1:0]   lookup_tag_i,
  output logic                  hit_o,
  output logic [31:0]           data_o,
  input  logic                  fill_en_i,
  input  logic [INDEX_BITS-1:0] fill_index_i,
  input  logic [TAG_BITS-1:0]   fill_tag_i,
  input  logic [31:0]           fill_data_i,
  input  logic                  invalidate_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  // Invalidate beats a fill on the same line, so a flush racing a fill leaves it invalid.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q[gi] <= 1'b0;
      end else if (invalidate_i) begin
        valid_q[gi] <= 1'b0;
      end else if (fill_en_i && (fill_index_i == INDEX_BITS'(gi))) begin
        valid_q[gi] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_index_i]  <= fill_tag_i;
      data_q[fill_index_i] <= fill_data_i;
    end
  end

  assign hit_o  = valid_q[lookup_index_i] && (tag_q[lookup_index_i] == lookup_tag_i);
  assign data_o = data_q[lookup_index_i];

endmodule

// File: rtl/flash_read_cache.sv
// Read-only word cache in front of the flash controller; hits complete in the
// request cycle, misses and writes pass through the down-side handshake.
module flash_read_cache
  import flash_read_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int INDEX_BITS = FLASH_CACHE_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] up_address,
  input  logic                  up_read,
  input  logic                  up_write,
  input  logic [3:0]            up_mask,
  input  logic [31:0]           up_data_wr,
  output logic [31:0]           up_data_rd,
  output logic                  up_stall,
  output logic [ADDR_WIDTH-1:0] down_address,
  output logic                  down_read,
  output logic                  down_write,
  output logic [3:0]            down_mask,
  output logic [31:0]           down_data_wr,
  input  logic [31:0]           down_data_rd,
  input  logic                  down_stall,
  input  logic                  flush,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS;

  FlashCacheState_t      state_q, state_d;
  logic [ADDR_WIDTH-1:0] down_address_q, down_address_d;
  logic                  down_read_q, down_read_d;
  logic                  down_write_q, down_write_d;
  logic [3:0]            down_mask_q, down_mask_d;
  logic [31:0]           down_data_wr_q, down_data_wr_d;
  logic [31:0]           resp_data_q, resp_data_d;
  logic                  cancel_fill_q, cancel_fill_d;
  logic [31:0]           hit_count_q, hit_count_d;
  logic [31:0]           miss_count_q, miss_count_d;

  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic        fill_en;
  logic        invalidate;

  flash_cache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clk           (clk),
    .rst           (rst),
    .lookup_index_i(up_address[INDEX_BITS-1:0]),
    .lookup_tag_i  (up_address[ADDR_WIDTH-1:INDEX_BITS]),
    .hit_o         (lookup_hit),
    .data_o        (lookup_data),
    .fill_en_i     (fill_en),
    .fill_index_i  (down_address_q[INDEX_BITS-1:0]),
    .fill_tag_i    (down_address_q[ADDR_WIDTH-1:INDEX_BITS]),
    .fill_data_i   (down_data_rd),
    .invalidate_i  (invalidate)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      down_address_q <= '0;
      down_read_q    <= 1'b0;
      down_write_q   <= 1'b0;
      down_mask_q    <= '0;
      down_data_wr_q <= '0;
      resp_data_q    <= '0;
      cancel_fill_q  <= 1'b0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      down_address_q <= down_address_d;
      down_read_q    <= down_read_d;
      down_write_q   <= down_write_d;
      down_mask_q    <= down_mask_d;
      down_data_wr_q <= down_data_wr_d;
      resp_data_q    <= resp_data_d;
      cancel_fill_q  <= cancel_fill_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
    end
  end

  // While an access is in flight, down_read_q doubles as the "this is a read" flag.
  always_comb begin
    state_d        = state_q;
    down_address_d = down_address_q;
    down_read_d    = down_read_q;
    down_write_d   = down_write_q;
    down_mask_d    = down_mask_q;
    down_data_wr_d = down_data_wr_q;
    resp_data_d    = resp_data_q;
    cancel_fill_d  = cancel_fill_q;
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;
    up_stall       = 1'b0;
    up_data_rd     = '0;
    fill_en        = 1'b0;
    invalidate     = flush;

    unique case (state_q)
      ST_IDLE: begin
        if (up_read && lookup_hit) begin
          up_data_rd  = lookup_data;
          hit_count_d = hit_count_q + 32'd1;
        end else if (up_read || up_write) begin
          up_stall       = 1'b1;
          down_address_d = up_address;
          down_mask_d    = up_mask;
          down_data_wr_d = up_data_wr;
          down_read_d    = up_read;
          down_write_d   = !up_read;
          cancel_fill_d  = 1'b0;
          if (up_read) begin
            miss_count_d = miss_count_q + 32'd1;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        up_stall = 1'b1;
        if (flush && down_read_q) begin
          cancel_fill_d = 1'b1;
        end
        if (down_stall) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        up_stall = 1'b1;
        if (flush && down_read_q) begin
          cancel_fill_d = 1'b1;
        end
        if (!down_stall) begin
          down_read_d  = 1'b0;
          down_write_d = 1'b0;
          resp_data_d  = down_data_rd;
          if (down_read_q) begin
            fill_en = !cancel_fill_q;
          end else begin
            invalidate = 1'b1;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        up_data_rd = resp_data_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign down_address = down_address_q;
  assign down_read    = down_read_q;
  assign down_write   = down_write_q;
  assign down_mask    = down_mask_q;
  assign down_data_wr = down_data_wr_q;
  assign hit_count    = hit_count_q;
  assign miss_count   = miss_count_q;

endmodule

// File: doc/flash_read_cache.md
# flash_read_cache

Direct-mapped, read-only word cache between the CPU-side data bus and `flash_controller`. Read hits return in zero added cycles instead of the controller's multi-cycle, two-halfword flash access. Reads that miss, and all writes, go to the controller through the same read/write/stall handshake. Any write, or an external flush, invalidates the whole cache, because flash writes are commands that change what reads return.

## Interface
Parameters:
- `ADDR_WIDTH`, 22: width of the word address on both sides.
- `INDEX_BITS`, 4: log2 of the line count; default 16 lines of one 32-bit word each.

Ports:
- `clk` in 1: bus clock (the same `base` clock the controller uses as `clk_bus`).
- `rst` in 1: asynchronous, active-high reset.
- `up_address` in `ADDR_WIDTH`: word address from the bus master.
- `up_read`, `up_write` in 1: request strobes, held until a cycle with `up_stall` = 0.
- `up_mask` in 4: byte mask, forwarded unchanged.
- `up_data_wr` in 32: write data, forwarded unchanged.
- `up_data_rd` out 32: read data.
- `up_stall` out 1: combinational; 1 while the request is not complete.
- `down_address` out `ADDR_WIDTH`, registered.
- `down_read`, `down_write` out 1, registered.
- `down_mask` out 4, registered.
- `down_data_wr` out 32, registered.
- `down_data_rd` in 32: data from the controller.
- `down_stall` in 1: stall from the controller.
- `flush` in 1: one-cycle pulse; invalidates all lines.
- `hit_count`, `miss_count` out 32: wrapping event counters.

## Operation
- Address split:
  - index = `up_address[INDEX_BITS-1:0]`.
  - tag = `up_address[ADDR_WIDTH-1:INDEX_BITS]`.
  - hit = valid[index] && tag match.
- State machine: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `up_read` && hit: `up_data_rd` = line data, `up_stall` = 0, `hit_count` +1. State stays IDLE.
  - `up_read` && !hit:
    - Latch address, mask and data into the `down_*` registers.
    - `down_read` <= 1; `miss_count` +1; go to ISSUE.
  - `up_write` (with no `up_read`):
    - Latch the `down_*` registers; `down_write` <= 1; go to ISSUE.
  - Read takes priority when `up_read` and `up_write` are both set; the write is not started.
- ISSUE:
  - Hold the strobe until `down_stall` = 1 is sampled, then go to WAIT.
  - The controller registers stall on a bus-clock falling edge, so ISSUE lasts at least one cycle.
- WAIT:
  - Stay until `down_stall` = 0 is sampled.
  - On that edge:
    - Clear `down_read`/`down_write`.
    - Capture `down_data_rd` into `resp_data`.
    - For a read that is not cancelled: write tag, data and valid into the line.
    - For a write: clear all valid bits.
  - Go to DONE.
- DONE: `up_stall` = 0 and `up_data_rd` = `resp_data` for exactly one cycle; go to IDLE. The master must drop or change its strobe after DONE.
- `up_stall` = 1 in these cases:
  - State is ISSUE or WAIT.
  - State is IDLE with `up_read` && !hit.
  - State is IDLE with `up_write`.
- `up_stall` = 0 in all other cases.
- `flush`:
  - Clears all valid bits on the next edge.
  - If the state is ISSUE or WAIT with a read in flight, set `cancel_fill`. The fill is then not installed, but the data is still returned in DONE.
  - A flush and a fill landing in the same cycle: flush wins, and the line ends invalid.
- `up_data_rd` in IDLE with no hit, and in ISSUE/WAIT: 0.

## Timing
- Reset values:
  - State IDLE; all valid bits 0.
  - `down_read`, `down_write` 0.
  - `down_address`, `down_mask`, `down_data_wr` 0.
  - `resp_data`, `hit_count`, `miss_count` 0; `cancel_fill` 0.
  - `up_stall` follows the combinational rule above.
- Reset mid-operation returns to IDLE immediately with the strobes low. The controller finishes its own access, which is safe.
- Hit latency: 0 extra cycles (same cycle as the request).
- Miss/write latency: 1 (ISSUE entry) + controller busy time + 1 (DONE) bus cycles.
- Tag and data storage are written only in WAIT; a lookup in the same cycle sees the old contents.
- Counters wrap from 0xFFFFFFFF to 0.

## Structure
- Shared package, next to the existing bus typedefs:
  - `FlashCacheState_t` enum.
  - `FLASH_CACHE_INDEX_BITS` default constant.
- Sub-module `flash_cache_array`:
  - Holds valid, tag and data vectors.
  - Combinational lookup port, one fill port, single-cycle bulk-invalidate input.
- The top level holds the FSM, the `down_*` registers and the counters.

## Test plan
- Reset asserted mid-WAIT: next cycle state IDLE, `down_read` = 0, all valid bits 0, counters 0.
- Read 0x000010 cold; model returns 0xDEADBEEF after 8 cycles:
  - `up_stall` high until DONE, then `up_data_rd` = 0xDEADBEEF.
  - `miss_count` = 1.
  - Re-read 0x000010: same-cycle 0xDEADBEEF, `hit_count` = 1, no downstream strobe.
- Conflict: read 0x000010, then 0x000020 (same index, different tag), then 0x000010: three misses, `miss_count` = 3.
- Fill 0x000010, write 0x00FF to 0x000000 (`up_mask` = 0011): `down_write` pulse, then read 0x000010 misses again.
- Pulse `flush` during WAIT of a miss on 0x000030:
  - Data is still returned in DONE.
  - An immediate re-read misses.
- `up_read` and `up_write` both high on a miss: only `down_read` asserted, `down_write` stays 0.
